// File: rtl/wb_pkg.sv
// Shared definitions for the multi-lane write-back stage: trace field widths,
// the trace entry layout and the MIPS ExcCode values reported to CP0.
package wb_pkg;

    localparam int PC_W         = 32;
    localparam int EXC_CODE_W   = 5;
    localparam int TRACE_WNUM_W = 5;
    localparam int TRACE_DATA_W = 32;

    localparam logic [3:0] TRACE_WEN = 4'hF;

    typedef enum logic [EXC_CODE_W-1:0] {
        EXC_INT  = 5'h00,
        EXC_MOD  = 5'h01,
        EXC_TLBL = 5'h02,
        EXC_TLBS = 5'h03,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0a,
        EXC_OV   = 5'h0c
    } exc_code_e;

    // One committed register write as seen on the debug trace port.
    typedef struct packed {
        logic [PC_W-1:0]         pc;
        logic [TRACE_WNUM_W-1:0] wnum;
        logic [TRACE_DATA_W-1:0] wdata;
    } trace_t;

endpackage

// File: rtl/wb_trace_fifo.sv
// Trace FIFO: up to LANES ordered writes per cycle (lowest set mask bit lands
// first), one read per cycle whenever non-empty. Depth need not be a power of 2.
module wb_trace_fifo #(
    parameter int W     = 69,
    parameter int DEPTH = 8,
    parameter int LANES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [LANES-1:0]               enq_mask,
    input  logic [LANES-1:0][W-1:0]        enq_data,
    output logic                           deq_valid,
    output logic [W-1:0]                   deq_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] slot [LANES];
    int            enq_total;

    // Pointer advance with wrap at DEPTH; n never exceeds DEPTH.
    function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return AW'(s);
    endfunction

    assign deq_valid = (count != '0);
    assign deq_data  = mem[rd_ptr];

    // Compact the enqueue mask: each set lane takes the next free slot in lane order.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        enq_total = 0;
        for (int i = 0; i < LANES; i++) begin
            slot[i] = wrap_add(wr_ptr, enq_total);
            // NOTE: blocking here on purpose -- the running total feeds the next lane in the same pass.
            if (enq_mask[i]) enq_total = enq_total + 1;
        end
    end

    // Pointers and occupancy; overflow is prevented upstream and checked here.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            enq_overflow: assert (int'(count) + enq_total - int'(deq_valid) <= DEPTH);
            wr_ptr <= wrap_add(wr_ptr, enq_total);
            if (deq_valid) rd_ptr <= wrap_add(rd_ptr, 1);
            count <= CW'(int'(count) + enq_total - int'(deq_valid));
        end
    end

    // Storage array: write the compacted entries.
    always_ff @(posedge clk) begin
        // NOTE: the array is not reset; count gates every read, so stale contents are never visible.
        for (int i = 0; i < LANES; i++) begin
            if (enq_mask[i]) mem[slot[i]] <= enq_data[i];
        end
    end

endmodule

// File: rtl/wb_stage_mlane.sv
// Multi-lane write-back stage: commits an issue group in program order with
// precise-exception masking, drives the RF ports and CP0 exception/eret
// requests, and serialises committed writes onto the debug trace port.
module wb_stage_mlane
    import wb_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int EXC_W       = EXC_CODE_W,
    parameter int TRACE_DEPTH = 8      // must be >= 2*LANES
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      ws_allowin,
    input  logic                      ms_to_ws_valid,
    input  logic [LANES-1:0]          ms_lane_valid,
    input  logic [LANES*PC_W-1:0]     ms_pc,
    input  logic [LANES-1:0]          ms_gr_we,
    input  logic [LANES*REG_AW-1:0]   ms_dest,
    input  logic [LANES*DATA_W-1:0]   ms_result,
    input  logic [LANES-1:0]          ms_ex,
    input  logic [LANES*EXC_W-1:0]    ms_excode,
    input  logic [LANES-1:0]          ms_bd,
    input  logic [LANES-1:0]          ms_eret,
    input  logic                      ms_mfc0,
    input  logic [DATA_W-1:0]         cp0_rdata,
    output logic [LANES-1:0]          rf_we,
    output logic [LANES*REG_AW-1:0]   rf_waddr,
    output logic [LANES*DATA_W-1:0]   rf_wdata,
    output logic [LANES*REG_AW-1:0]   wb_dest,
    output logic [LANES*DATA_W-1:0]   wb_result,
    output logic                      ex_req,
    output logic [PC_W-1:0]           ex_pc,
    output logic [EXC_W-1:0]          ex_excode,
    output logic                      ex_bd,
    output logic                      eret_req,
    output logic                      flush,
    output logic [PC_W-1:0]           debug_wb_pc,
    output logic [3:0]                debug_wb_rf_wen,
    output logic [4:0]                debug_wb_rf_wnum,
    output logic [31:0]               debug_wb_rf_wdata
);

    // Stored issue group
    logic                          ws_valid;
    logic                          mfc0;
    logic [LANES-1:0]              lane_valid, gr_we, ex, bd, eret;
    logic [LANES-1:0][PC_W-1:0]    pc;
    logic [LANES-1:0][REG_AW-1:0]  dest;
    logic [LANES-1:0][DATA_W-1:0]  result;
    logic [LANES-1:0][EXC_W-1:0]   excode;

    // Commit decode
    logic [LANES-1:0]              live;
    logic [LANES-1:0][DATA_W-1:0]  lane_data;
    logic [LANES-1:0][REG_AW-1:0]  fwd_dest;
    logic                          kill_seen, k_live, k_ex, k_eret, k_bd;
    logic [PC_W-1:0]               k_pc;
    logic [EXC_W-1:0]              k_code;

    // Trace FIFO side
    trace_t [LANES-1:0]                  trace_in;
    trace_t                              trace_head;
    logic                                deq_valid;
    logic [$clog2(TRACE_DEPTH+1)-1:0]    fifo_count;
    int                                  enq_now;

    // Stage register: flush or a full trace FIFO retires the group without a replacement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush || !ws_allowin) begin
            ws_valid   <= 1'b0;
            mfc0       <= 1'b0;
            lane_valid <= '0;
            gr_we      <= '0;
            ex         <= '0;
            bd         <= '0;
            eret       <= '0;
            pc         <= '0;
            dest       <= '0;
            result     <= '0;
            excode     <= '0;
        end else begin
            ws_valid <= ms_to_ws_valid;
            if (ms_to_ws_valid) begin
                mfc0       <= ms_mfc0;
                lane_valid <= ms_lane_valid;
                gr_we      <= ms_gr_we;
                ex         <= ms_ex;
                bd         <= ms_bd;
                eret       <= ms_eret;
                pc         <= ms_pc;
                dest       <= ms_dest;
                result     <= ms_result;
                excode     <= ms_excode;
            end
        end
    end

    // Live mask and first killer: lanes younger than the first ex/eret are squashed.
    always_comb begin
        live      = '0;
        kill_seen = 1'b0;
        k_live    = 1'b0;
        k_ex      = 1'b0;
        k_eret    = 1'b0;
        k_bd      = 1'b0;
        k_pc      = '0;
        k_code    = '0;
        for (int i = 0; i < LANES; i++) begin
            live[i] = ws_valid && lane_valid[i] && !kill_seen;
            if (!kill_seen && (ex[i] || eret[i])) begin
                kill_seen = 1'b1;
                k_live    = live[i];
                k_ex      = ex[i];
                k_eret    = eret[i];
                k_bd      = bd[i];
                k_pc      = pc[i];
                k_code    = excode[i];
            end
        end
    end

    // Per-lane write enables, result mux (lane 0 may carry mfc0) and trace entries.
    always_comb begin
        lane_data = result;
        if (mfc0) lane_data[0] = cp0_rdata;
        for (int i = 0; i < LANES; i++) begin
            rf_we[i]    = live[i] && gr_we[i] && !ex[i] && !eret[i];
            fwd_dest[i] = live[i] ? dest[i] : '0;
            trace_in[i] = '{pc:    pc[i],
                            wnum:  TRACE_WNUM_W'(dest[i]),
                            wdata: TRACE_DATA_W'(lane_data[i])};
        end
    end

    assign rf_waddr  = dest;
    assign rf_wdata  = lane_data;
    assign wb_dest   = fwd_dest;
    assign wb_result = lane_data;

    // CP0 requests; the excepting lane's details are only shown while it commits.
    assign ex_req    = k_live && k_ex;
    assign eret_req  = k_live && k_eret && !k_ex;
    assign flush     = ex_req || eret_req;
    assign ex_pc     = ex_req ? k_pc   : '0;
    assign ex_excode = ex_req ? k_code : '0;
    assign ex_bd     = ex_req && k_bd;

    // Accept a new group only if the FIFO can still absorb a full group next cycle.
    always_comb begin
        enq_now = 0;
        for (int i = 0; i < LANES; i++) begin
            if (rf_we[i]) enq_now = enq_now + 1;
        end
        ws_allowin = !reset &&
                     (int'(fifo_count) + enq_now - int'(deq_valid) + LANES <= TRACE_DEPTH);
    end

    wb_trace_fifo #(
        .W     ($bits(trace_t)),
        .DEPTH (TRACE_DEPTH),
        .LANES (LANES)
    ) u_trace_fifo (
        .clk       (clk),
        .reset     (reset),
        .enq_mask  (rf_we),
        .enq_data  (trace_in),
        .deq_valid (deq_valid),
        .deq_data  (trace_head),
        .count     (fifo_count)
    );

    assign debug_wb_pc       = deq_valid ? trace_head.pc    : '0;
    assign debug_wb_rf_wen   = deq_valid ? TRACE_WEN        : 4'h0;
    assign debug_wb_rf_wnum  = deq_valid ? trace_head.wnum  : '0;
    assign debug_wb_rf_wdata = deq_valid ? trace_head.wdata : '0;

endmodule

// File: tb/tb_wb_stage_mlane.sv
// Self-checking bench for wb_stage_mlane: directed scenarios plus randomized
// groups, compared against a group-level model with a queue for the trace.
module tb_wb_stage_mlane;
    import wb_pkg::*;

    localparam int LANES  = 2;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int EXC_W  = 5;
    localparam int DEPTH  = 8;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic        ex;
        logic [4:0]  excode;
        logic        bd;
        logic        eret;
    } lane_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trace_e;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      ws_allowin;
    logic                      ms_to_ws_valid;
    logic [LANES-1:0]          ms_lane_valid;
    logic [LANES*32-1:0]       ms_pc;
    logic [LANES-1:0]          ms_gr_we;
    logic [LANES*REG_AW-1:0]   ms_dest;
    logic [LANES*DATA_W-1:0]   ms_result;
    logic [LANES-1:0]          ms_ex;
    logic [LANES*EXC_W-1:0]    ms_excode;
    logic [LANES-1:0]          ms_bd;
    logic [LANES-1:0]          ms_eret;
    logic                      ms_mfc0;
    logic [DATA_W-1:0]         cp0_rdata;
    logic [LANES-1:0]          rf_we;
    logic [LANES*REG_AW-1:0]   rf_waddr;
    logic [LANES*DATA_W-1:0]   rf_wdata;
    logic [LANES*REG_AW-1:0]   wb_dest;
    logic [LANES*DATA_W-1:0]   wb_result;
    logic                      ex_req;
    logic [31:0]               ex_pc;
    logic [EXC_W-1:0]          ex_excode;
    logic                      ex_bd;
    logic                      eret_req;
    logic                      flush;
    logic [31:0]               debug_wb_pc;
    logic [3:0]                debug_wb_rf_wen;
    logic [4:0]                debug_wb_rf_wnum;
    logic [31:0]               debug_wb_rf_wdata;

    wb_stage_mlane #(
        .LANES(LANES), .DATA_W(DATA_W), .REG_AW(REG_AW), .EXC_W(EXC_W), .TRACE_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_lane_valid(ms_lane_valid), .ms_pc(ms_pc),
        .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result), .ms_ex(ms_ex),
        .ms_excode(ms_excode), .ms_bd(ms_bd), .ms_eret(ms_eret), .ms_mfc0(ms_mfc0),
        .cp0_rdata(cp0_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wb_dest(wb_dest), .wb_result(wb_result), .ex_req(ex_req), .ex_pc(ex_pc),
        .ex_excode(ex_excode), .ex_bd(ex_bd), .eret_req(eret_req), .flush(flush),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    // Stimulus and reference state
    lane_t       in_lane [LANES];
    lane_t       m_lane  [LANES];
    logic        m_valid;
    logic        m_mfc0;
    trace_e      q [$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] pc_ctr = 32'hBFC0_0100;
    logic        acc;
    logic        stall_seen;
    int          n_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < LANES; i++) begin
            ms_lane_valid[i]          = in_lane[i].v;
            ms_pc[i*32 +: 32]         = in_lane[i].pc;
            ms_gr_we[i]               = in_lane[i].we;
            ms_dest[i*REG_AW +: REG_AW] = in_lane[i].dest;
            ms_result[i*DATA_W +: DATA_W] = in_lane[i].result;
            ms_ex[i]                  = in_lane[i].ex;
            ms_excode[i*EXC_W +: EXC_W] = in_lane[i].excode;
            ms_bd[i]                  = in_lane[i].bd;
            ms_eret[i]                = in_lane[i].eret;
        end
    endtask

    task automatic idle();
        for (int i = 0; i < LANES; i++) in_lane[i] = '{default: 0};
        ms_to_ws_valid = 1'b0;
        ms_mfc0        = 1'b0;
        apply();
    endtask

    task automatic set_lane(input int i, input logic [31:0] pc, input logic we,
                            input logic [4:0] dest, input logic [31:0] res,
                            input logic ex, input logic [4:0] code,
                            input logic bd, input logic eret);
        in_lane[i] = '{v: 1'b1, pc: pc, we: we, dest: dest, result: res,
                       ex: ex, excode: code, bd: bd, eret: eret};
    endtask

    task automatic full_group();
        for (int i = 0; i < LANES; i++) begin
            set_lane(i, pc_ctr, 1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0, 5'd0, 1'b0, 1'b0);
            pc_ctr = pc_ctr + 4;
        end
        ms_to_ws_valid = 1'b1;
        ms_mfc0        = 1'b0;
        apply();
    endtask

    task automatic rand_group();
        ms_to_ws_valid = ($urandom_range(0, 9) < 8);
        ms_mfc0        = ($urandom_range(0, 9) == 0);
        for (int i = 0; i < LANES; i++) begin
            in_lane[i].v      = ($urandom_range(0, 3) != 0);
            in_lane[i].pc     = pc_ctr;
            in_lane[i].we     = ($urandom_range(0, 3) != 0);
            in_lane[i].dest   = 5'($urandom);
            in_lane[i].result = $urandom;
            in_lane[i].ex     = in_lane[i].v && ($urandom_range(0, 11) == 0);
            in_lane[i].excode = 5'($urandom);
            in_lane[i].bd     = 1'($urandom);
            in_lane[i].eret   = in_lane[i].v && !in_lane[i].ex && ($urandom_range(0, 19) == 0);
            pc_ctr = pc_ctr + 4;
        end
        apply();
    endtask

    // One WB cycle: called just after a falling edge with inputs driven; predicts
    // every output from the modelled group and trace queue, then advances the model.
    task automatic step(output logic accepted);
        logic [LANES-1:0] e_we;
        logic             e_ex, e_eret, e_bd, killed, live, e_allow, e_deq, fl;
        logic [31:0]      e_pc, data;
        logic [4:0]       e_code;
        trace_e           commits [$];
        #1;
        e_we = '0; e_ex = 1'b0; e_eret = 1'b0; e_bd = 1'b0; e_pc = '0; e_code = '0;
        killed = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            live = m_valid && m_lane[i].v && !killed;
            data = (i == 0 && m_mfc0) ? cp0_rdata : m_lane[i].result;
            check($sformatf("wb_dest%0d", i), 64'(wb_dest[i*REG_AW +: REG_AW]),
                  64'(live ? m_lane[i].dest : 5'd0));
            if (live && m_lane[i].we && !m_lane[i].ex && !m_lane[i].eret) begin
                e_we[i] = 1'b1;
                commits.push_back('{pc: m_lane[i].pc, wnum: m_lane[i].dest, wdata: data});
                check($sformatf("rf_waddr%0d", i), 64'(rf_waddr[i*REG_AW +: REG_AW]), 64'(m_lane[i].dest));
                check($sformatf("rf_wdata%0d", i), 64'(rf_wdata[i*DATA_W +: DATA_W]), 64'(data));
                check($sformatf("wb_result%0d", i), 64'(wb_result[i*DATA_W +: DATA_W]), 64'(data));
            end
            if (!killed && (m_lane[i].ex || m_lane[i].eret)) begin
                killed = 1'b1;
                if (live) begin
                    e_ex   = m_lane[i].ex;
                    e_eret = m_lane[i].eret && !m_lane[i].ex;
                    if (m_lane[i].ex) begin
                        e_pc   = m_lane[i].pc;
                        e_code = m_lane[i].excode;
                        e_bd   = m_lane[i].bd;
                    end
                end
            end
        end
        fl      = e_ex || e_eret;
        e_deq   = (q.size() != 0);
        e_allow = !reset && (q.size() + commits.size() - int'(e_deq) + LANES <= DEPTH);
        check("rf_we",      64'(rf_we),      64'(e_we));
        check("ex_req",     64'(ex_req),     64'(e_ex));
        check("eret_req",   64'(eret_req),   64'(e_eret));
        check("flush",      64'(flush),      64'(fl));
        check("ex_pc",      64'(ex_pc),      64'(e_pc));
        check("ex_excode",  64'(ex_excode),  64'(e_code));
        check("ex_bd",      64'(ex_bd),      64'(e_bd));
        check("ws_allowin", 64'(ws_allowin), 64'(e_allow));
        check("trace_wen",  64'(debug_wb_rf_wen),   64'(e_deq ? 4'hF : 4'h0));
        check("trace_pc",   64'(debug_wb_pc),       64'(e_deq ? q[0].pc : 32'd0));
        check("trace_wnum", 64'(debug_wb_rf_wnum),  64'(e_deq ? q[0].wnum : 5'd0));
        check("trace_data", 64'(debug_wb_rf_wdata), 64'(e_deq ? q[0].wdata : 32'd0));
        accepted = e_allow && ms_to_ws_valid && !reset;
        @(posedge clk);
        if (!reset) begin
            if (e_deq) void'(q.pop_front());
            foreach (commits[j]) q.push_back(commits[j]);
            if (fl || !e_allow) begin
                m_valid = 1'b0;
            end else begin
                m_valid = ms_to_ws_valid;
                if (ms_to_ws_valid) begin
                    m_lane = in_lane;
                    m_mfc0 = ms_mfc0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        idle();
        for (int c = 0; c < n; c++) step(acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cp0_rdata = '0;
        m_valid   = 1'b0;
        m_mfc0    = 1'b0;
        for (int i = 0; i < LANES; i++) m_lane[i] = '{default: 0};
        idle();
        @(negedge clk);
        step(acc);                      // outputs held at zero during reset
        reset = 1'b0;

        // Two lanes writing in the same group; trace shows them in lane order
        set_lane(0, 32'hBFC0_0000, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 1'b0, 1'b0);
        set_lane(1, 32'hBFC0_0004, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0, 1'b0, 1'b0);
        ms_to_ws_valid = 1'b1;
        apply();
        step(acc);
        drain(4);

        // Lane 0 exception in a delay slot squashes lane 1; the next group is dropped
        set_lane(0, 32'hBFC0_0010, 1'b1, 5'd6, 32'h33, 1'b1, EXC_OV, 1'b1, 1'b0);
        set_lane(1, 32'hBFC0_0014, 1'b1, 5'd7, 32'h44, 1'b0, 5'd0, 1'b0, 1'b0);
        ms_to_ws_valid = 1'b1;
        apply();
        step(acc);
        full_group();                   // presented during the flush cycle
        step(acc);
        drain(4);

        // Lane 0 writes, lane 1 eret: single trace entry
        set_lane(0, 32'hBFC0_0020, 1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 1'b0, 1'b0);
        set_lane(1, 32'hBFC0_0024, 1'b1, 5'd8, 32'h66, 1'b0, 5'd0, 1'b0, 1'b1);
        ms_to_ws_valid = 1'b1;
        apply();
        step(acc);
        drain(4);

        // Back-to-back full groups until ten are accepted; back-pressure must appear
        stall_seen = 1'b0;
        n_acc      = 0;
        full_group();
        for (int c = 0; c < 40 && n_acc < 10; c++) begin
            step(acc);
            if (ws_allowin === 1'b0) stall_seen = 1'b1;
            if (acc) begin
                n_acc++;
                if (n_acc < 10) full_group();
                else idle();
            end
        end
        check("b2b_accepted", 64'(n_acc), 64'd10);
        check("b2b_stall_seen", 64'(stall_seen), 64'd1);
        drain(20);

        // Lane-0 mfc0 takes CP0 read data
        set_lane(0, 32'hBFC0_0030, 1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 1'b0, 1'b0);
        set_lane(1, 32'hBFC0_0034, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        ms_to_ws_valid = 1'b1;
        ms_mfc0        = 1'b1;
        apply();
        step(acc);
        idle();
        cp0_rdata = 32'hDEAD_BEEF;
        #1;
        check("mfc0_rf_wdata", 64'(rf_wdata[31:0]), 64'hDEAD_BEEF);
        check("mfc0_wb_result", 64'(wb_result[31:0]), 64'hDEAD_BEEF);
        step(acc);
        cp0_rdata = '0;
        drain(4);

        // Reset with five trace entries queued and a group in WB
        full_group();
        for (int c = 0; c < 30 && !(q.size() == 5 && m_valid); c++) begin
            step(acc);
            if (acc) full_group();
        end
        check("pre_reset_fill", 64'(q.size() == 5 && m_valid), 64'd1);
        reset = 1'b1;
        idle();
        m_valid = 1'b0;
        q.delete();
        #1;
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_rf_wdata", 64'(rf_wdata), 64'd0);
        check("rst_wb_result", 64'(wb_result), 64'd0);
        check("rst_allowin", 64'(ws_allowin), 64'd0);
        check("rst_trace_wen", 64'(debug_wb_rf_wen), 64'd0);
        check("rst_trace_pc", 64'(debug_wb_pc), 64'd0);
        step(acc);
        reset = 1'b0;
        drain(5);

        // Randomized groups, held until accepted
        rand_group();
        for (int c = 0; c < 400; c++) begin
            cp0_rdata = $urandom;
            step(acc);
            if (acc || !ms_to_ws_valid) rand_group();
        end
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
